// File: rtl/dmem_responder.sv
// Handshaked, wait-stated data memory with byte-write strobes and error response.
// Optional: define DMEM_MISALIGN_ERR_EN to flag non-word-aligned accesses as errors.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          acc_err;
    logic          do_access;

    assign idx       = addr_q[AW+1:2];
    assign do_access = (state == WAIT) && (cnt == '0);
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);

    // Full word index is compared so out-of-range addresses never alias onto low words.
    always_comb begin
        acc_err = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
`ifdef DMEM_MISALIGN_ERR_EN
        if (addr_q[1:0] != 2'b00)
            acc_err = 1'b1;
`endif
    end

`ifndef DMEM_MISALIGN_ERR_EN
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_err || write_q) ? '0 : mem[idx];
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; rst gating keeps an interrupted store uncommitted.
    always_ff @(posedge clk) begin
        if (!rst && do_access && write_q && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb_q[i])
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, WAIT_CYCLES=2).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one request and complete its response with rsp_ready high.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                          output int lat, output int acc_cyc);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready got %b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_cyc = cyc;
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid got %b required 1", rsp_valid);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 00000000", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", rsp_err); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic er; int lat; int ac;
        do_req(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, lat, ac);
        checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency: got %0d required 4", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b required 0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h required 00000000", rd); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL load_rdata: got %h required cafef00d", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b required 0", er); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL load_latency: got %0d required 4", lat); end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] rd; logic er; int lat; int ac;
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0010, rd, er, lat, ac);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'hCAFE330D) begin errors++; $display("FAIL strobe_rdata: got %h required cafe330d", rd); end
    endtask

    task automatic test_backpressure;
        int n;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'hF;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b required 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 32'hCAFE330D) begin errors++; $display("FAIL bp_rdata[%0d]: got %h required cafe330d", i, rsp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b required 0", i, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_req_ready: got %b required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_rsp_valid: got %b required 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat; int ac1; int ac2;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ac1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ac2);
        checks++; if (ac2 - ac1 !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d required 5", ac2 - ac1); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic er; int lat; int ac;
        do_req(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat, ac);
        do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat, ac);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err: got %b required 1", er); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL oor_alias_rdata: got %h required 12345678", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_alias_err: got %b required 0", er); end
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_load_err: got %b required 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_load_rdata: got %h required 00000000", rd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL oor_latency: got %0d required 4", lat); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic er; int lat; int ac;
        do_req(1'b1, 32'h12, 32'hAAAAAAAA, 4'hF, rd, er, lat, ac);
`ifdef DMEM_MISALIGN_ERR_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b required 1", er); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'hCAFE330D) begin errors++; $display("FAIL misalign_rdata: got %h required cafe330d", rd); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL misalign_err: got %b required 0", er); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'hAAAAAAAA) begin errors++; $display("FAIL misalign_rdata: got %h required aaaaaaaa", rd); end
`endif
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd; logic er; int lat; int ac; int n;
        do_req(1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat, ac);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_wstrb = 4'hF;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_req_ready: got %b required 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rsp_rdata: got %h required 00000000", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL midrst_rsp_err: got %b required 0", rsp_err); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b required 1", req_ready); end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, ac);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_load_rdata: got %h required 00000000", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL midrst_load_err: got %b required 0", er); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_strobe;
        test_backpressure;
        test_back_to_back;
        test_out_of_range;
        test_misalign;
        test_reset_mid_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
